// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings and constants for the fetch controller.
package fetch_ctrl_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FC_FETCH = 2'd0,
      FC_WAIT  = 2'd1,
      FC_DROP  = 2'd2,
      FC_HOLD  = 2'd3
   } fc_state_e;

   localparam word_t INST_NOP    = 32'h0000_0013;
   localparam word_t FC_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel: req/ready accept, then one rvalid per accepted request.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic  imem_req;
   word_t imem_addr;
   logic  imem_ready;
   logic  imem_rvalid;
   word_t imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer / fetch controller: one outstanding imem request, >=3 cycles per instruction.
// Decode stall holds the presented instruction; redirects squash in-flight or held fetches.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter word_t RESET_PC = FC_RESET_PC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                redirect_valid,
   input  word_t               redirect_pc,
   input  logic                stall,
   fetch_ctrl_if.master        imem,
   output logic                if_valid,
   output word_t               if_pc,
   output word_t               if_inst,
   output word_t               if_pc4
);

   fc_state_e state_q, state_d;
   word_t     addr_q, addr_d;
   word_t     nxt_pc_q, nxt_pc_d;
   logic      drop_q, drop_d;
   logic      if_valid_q, if_valid_d;
   word_t     if_pc_q, if_pc_d;
   word_t     if_inst_q, if_inst_d;
   word_t     target;

   // Every entry into FETCH picks the redirect target if one is present this cycle.
   assign target = redirect_valid ? redirect_pc : nxt_pc_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      nxt_pc_d   = nxt_pc_q;
      drop_d     = drop_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;

      unique case (state_q)
         FC_FETCH: begin
            if (imem.imem_ready) begin
               state_d = (drop_q || redirect_valid) ? FC_DROP : FC_WAIT;
               drop_d  = 1'b0;
               if (redirect_valid) nxt_pc_d = redirect_pc;
            end else if (redirect_valid) begin
               // Address must stay put until accepted; remember to discard its response.
               nxt_pc_d = redirect_pc;
               drop_d   = 1'b1;
            end
         end
         FC_WAIT: begin
            if (imem.imem_rvalid && !redirect_valid) begin
               if_inst_d  = imem.imem_rdata;
               if_pc_d    = addr_q;
               if_valid_d = 1'b1;
               nxt_pc_d   = addr_q + 32'd4;
               state_d    = FC_HOLD;
            end else if (imem.imem_rvalid) begin
               state_d = FC_FETCH;
               addr_d  = target;
            end else if (redirect_valid) begin
               nxt_pc_d = redirect_pc;
               state_d  = FC_DROP;
            end
         end
         FC_DROP: begin
            if (redirect_valid) nxt_pc_d = redirect_pc;
            if (imem.imem_rvalid) begin
               state_d = FC_FETCH;
               addr_d  = target;
            end
         end
         FC_HOLD: begin
            if (redirect_valid || !stall) begin
               if_valid_d = 1'b0;
               state_d    = FC_FETCH;
               addr_d     = target;
            end
         end
         default: state_d = FC_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FC_FETCH;
         addr_q     <= RESET_PC;
         nxt_pc_q   <= RESET_PC;
         drop_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0000_0000;
         if_inst_q  <= INST_NOP;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         nxt_pc_q   <= nxt_pc_d;
         drop_q     <= drop_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   assign imem.imem_req  = rst_n && (state_q == FC_FETCH);
   assign imem.imem_addr = addr_q;
   assign if_valid       = if_valid_q;
   assign if_pc          = if_pc_q;
   assign if_inst        = if_inst_q;
   assign if_pc4         = if_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: transaction-level reference model, directed scenarios, then random traffic.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  redirect_valid = 1'b0;
   word_t redirect_pc = '0;
   logic  stall = 1'b0;
   logic  if_valid;
   word_t if_pc, if_inst, if_pc4;

   fetch_ctrl_if intf ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem           (intf),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .if_pc4         (if_pc4)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   // Reference model: a request being offered, a response owed, and an instruction on display.
   bit    m_offer;
   word_t m_addr;
   bit    m_owed;
   bit    m_keep;
   bit    m_squash;
   word_t m_next;
   bit    m_pres;
   word_t m_pc;
   word_t m_inst;

   // Memory responder state and knobs.
   bit    mem_busy = 1'b0;
   int    mem_cnt = 0;
   word_t mem_a = '0;
   int    mem_lat = 0;
   bit    rdy_allow = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue(input word_t a);
      m_offer = 1'b1;
      m_addr  = a;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_offer = 1'b1; m_addr = 32'h0; m_next = 32'h0; m_squash = 1'b0;
         m_owed = 1'b0; m_keep = 1'b0; m_pres = 1'b0;
         m_pc = 32'h0; m_inst = INST_NOP;
      end else if (m_offer) begin
         if (intf.imem_ready) begin
            m_offer  = 1'b0;
            m_owed   = 1'b1;
            m_keep   = !(m_squash || redirect_valid);
            m_squash = 1'b0;
            if (redirect_valid) m_next = redirect_pc;
         end else if (redirect_valid) begin
            m_next   = redirect_pc;
            m_squash = 1'b1;
         end
      end else if (m_owed) begin
         if (m_keep && intf.imem_rvalid && !redirect_valid) begin
            m_owed = 1'b0;
            m_pres = 1'b1;
            m_pc   = m_addr;
            m_inst = intf.imem_rdata;
            m_next = m_addr + 32'd4;
         end else begin
            if (redirect_valid) begin
               m_next = redirect_pc;
               m_keep = 1'b0;
            end
            if (intf.imem_rvalid) begin
               m_owed = 1'b0;
               issue(m_next);
            end
         end
      end else if (m_pres) begin
         if (redirect_valid) begin
            m_pres = 1'b0;
            issue(redirect_pc);
         end else if (!stall) begin
            m_pres = 1'b0;
            issue(m_next);
         end
      end
   endtask

   // Drive memory for the coming edge, take the edge, update memory and model, settle 1 time unit.
   task automatic step();
      intf.imem_ready  = !mem_busy && rdy_allow;
      intf.imem_rvalid = mem_busy && (mem_cnt == 0);
      intf.imem_rdata  = intf.imem_rvalid ? (mem_a ^ 32'hA5A5_0000) : $urandom;
      @(posedge clk);
      if (intf.imem_rvalid) mem_busy = 1'b0;
      else if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (rst_n && m_offer && intf.imem_ready) begin
         mem_busy = 1'b1;
         mem_cnt  = mem_lat;
         mem_a    = m_addr;
      end
      model_step();
      #1;
   endtask

   task automatic wait_pres(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!if_valid && n < budget);
      if (!if_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_if_valid: got timeout after %0d cycles expected if_valid", n);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("imem_req", intf.imem_req, rst_n && m_offer);
         if (rst_n && m_offer) chk("imem_addr", intf.imem_addr, m_addr);
         chk("if_valid", if_valid, m_pres);
         chk("if_pc", if_pc, m_pc);
         chk("if_inst", if_inst, m_inst);
         chk("if_pc4", if_pc4, m_pc + 32'd4);
      end
   end

   initial begin
      int n;
      intf.imem_ready = 1'b0; intf.imem_rvalid = 1'b0; intf.imem_rdata = '0;

      // Reset, then back-to-back fetch with single-cycle memory.
      rst_n = 1'b0;
      step();
      cmp_en = 1'b1;
      step();
      chk("rst_req", intf.imem_req, 1'b0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_inst", if_inst, 32'h0000_0013);
      rst_n = 1'b1; rdy_allow = 1'b1; mem_lat = 0;
      step();
      chk("first_addr", intf.imem_addr, 32'h0);
      wait_pres(20, n);
      chk("seq0_pc", if_pc, 32'h0);
      chk("seq0_pc4", if_pc4, 32'h4);
      chk("seq0_inst", if_inst, 32'hA5A5_0000);
      wait_pres(20, n);
      chk("pulse_gap", n, 3);
      chk("seq1_pc", if_pc, 32'h4);
      chk("seq1_pc4", if_pc4, 32'h8);

      // Decode stall while holding PC 4.
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid", if_valid, 1'b1);
         chk("stall_pc", if_pc, 32'h4);
         chk("stall_inst", if_inst, 32'hA5A5_0004);
         chk("stall_req", intf.imem_req, 1'b0);
      end
      stall = 1'b0;
      step();
      chk("post_stall_addr", intf.imem_addr, 32'h8);
      wait_pres(20, n);
      chk("seq2_pc", if_pc, 32'h8);
      chk("seq2_pc4", if_pc4, 32'hC);

      // Redirect while waiting for a response.
      mem_lat = 1;
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_valid = 1'b0;
      chk("wait_redir_valid", if_valid, 1'b0);
      step();
      chk("wait_redir_valid2", if_valid, 1'b0);
      chk("wait_redir_addr", intf.imem_addr, 32'h100);
      wait_pres(20, n);
      chk("redir_pc", if_pc, 32'h100);
      chk("redir_inst", if_inst, 32'hA5A5_0100);

      // Redirect while a request is stalled by imem_ready=0.
      rdy_allow = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
      step();
      redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      chk("hs_addr_a", intf.imem_addr, 32'h8);
      step();
      chk("hs_addr_b", intf.imem_addr, 32'h8);
      chk("hs_req_b", intf.imem_req, 1'b1);
      rdy_allow = 1'b1; mem_lat = 0;
      step();
      chk("hs_drop_valid", if_valid, 1'b0);
      step();
      chk("hs_new_addr", intf.imem_addr, 32'h200);
      chk("hs_new_req", intf.imem_req, 1'b1);

      // Redirect coincident with the response.
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("coinc_valid", if_valid, 1'b0);
      chk("coinc_addr", intf.imem_addr, 32'h40);
      chk("coinc_req", intf.imem_req, 1'b1);

      // Reset during WAIT with a late response.
      mem_lat = 2;
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_req", intf.imem_req, 1'b0);
      chk("midrst_valid", if_valid, 1'b0);
      rst_n = 1'b1;
      step();
      chk("midrst_addr", intf.imem_addr, 32'h0);
      step();
      chk("late_rvalid_valid", if_valid, 1'b0);
      chk("late_rvalid_req", intf.imem_req, 1'b1);
      wait_pres(30, n);
      chk("after_rst_pc", if_pc, 32'h0);

      // Address wrap.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0; mem_lat = 0;
      wait_pres(20, n);
      chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", if_pc4, 32'h0);
      step();
      chk("wrap_addr", intf.imem_addr, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rdy_allow      = ($urandom % 4) != 0;
         mem_lat        = $urandom % 3;
         stall          = ($urandom % 3) == 0;
         redirect_valid = ($urandom % 8) == 0;
         redirect_pc    = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
         step();
      end
      redirect_valid = 1'b0;
      stall = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
